ieee1355_rx: RTL
================

IEEE1355_RX -- requirements
Module: ieee1355_rx

Interface
REQ-001 The block SHALL have parameter G_TIMEOUT_CYCLES, default 64, giving the number of clk cycles without a bit event before link loss (range 8..1023).
REQ-002 The block SHALL run on one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have port clk, input, 1, system clock, at least 4x the maximum link bit rate.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port D_in, input, 1, asynchronous DS-link data line.
REQ-006 The block SHALL have port S_in, input, 1, asynchronous DS-link strobe line.
REQ-007 The block SHALL have port rx_data, output, 10, received character with bit 0 first on the wire.
REQ-008 The block SHALL have port rx_valid, output, 1, one-cycle strobe qualifying rx_data.
REQ-009 The block SHALL have port rx_is_null, output, 1, qualifier meaning the current rx_data is NULL; it is meaningful only with IEEE1355_RX_NULL_PASS_EN.
REQ-010 The block SHALL have port link_up, output, 1, level that is high while the receiver is aligned.
REQ-011 The block SHALL have port rx_err, output, 1, one-cycle strobe flagging a DS violation or timeout.

Function
REQ-012 D_in and S_in SHALL each pass through a two-flop synchroniser (d_s2, s_s2) before any use.
REQ-013 A bit event SHALL be detected when d_s2 XOR s_s2 differs from its value registered on the previous cycle.
REQ-014 On a bit event, the value of d_s2 SHALL be shifted into bit 9 of a 10-bit shift register and the contents shifted toward bit 0 (LSB-first).
REQ-015 An edge on a pin SHALL produce the corresponding shift-register update exactly 3 clk cycles later.
REQ-016 A DS violation SHALL be flagged when d_s2 and s_s2 both toggle in the same cycle.
REQ-017 On a DS violation, the block SHALL pulse rx_err for one cycle, shift no bit, and return to HUNT.
REQ-018 The FSM SHALL have exactly two states: HUNT and ALIGNED.
REQ-019 In HUNT, after every bit event the shift register SHALL be compared with NULL = 10'b1111000110.
REQ-020 In HUNT, a NULL match SHALL move the FSM to ALIGNED, clear bit_cnt to 0 and set link_up on the next cycle.
REQ-021 In ALIGNED, bit_cnt SHALL increment on each bit event; when the 10th bit arrives (bit_cnt = 9), the character is complete and bit_cnt wraps to 0.
REQ-022 On a complete non-NULL character, rx_data SHALL be loaded with the shift register and rx_valid pulsed for one cycle, 1 cycle after the 10th bit shift.
REQ-023 rx_data SHALL hold its value until the next load.
REQ-024 A complete NULL character SHALL be discarded when IEEE1355_RX_NULL_PASS_EN is undefined.
REQ-025 In ALIGNED, character boundaries SHALL be determined only by bit_cnt; a NULL pattern appearing mid-character SHALL NOT realign.
REQ-026 Timeout counter: it SHALL be cleared on every bit event and incremented otherwise, saturating at G_TIMEOUT_CYCLES.
REQ-027 When the timeout counter reaches G_TIMEOUT_CYCLES in ALIGNED, the block SHALL return to HUNT, clear link_up and pulse rx_err once.
REQ-028 A timeout in HUNT SHALL NOT assert rx_err.
REQ-029 If a bit event and timeout expiry coincide, the bit event SHALL take priority and no timeout occurs.
REQ-030 If a DS violation and 10th-bit completion coincide, the violation SHALL take priority and no character is emitted.
REQ-031 The outputs rx_valid and rx_err SHALL never be high for more than one consecutive cycle per event.

Reset
REQ-032 While rst is high at a rising clk edge, all registers SHALL clear.
REQ-033 Reset values: rx_data=0, rx_valid=0, rx_is_null=0, link_up=0, rx_err=0, FSM=HUNT, bit_cnt=0, timeout=0, synchronisers=0, shift register=0.
REQ-034 Reset asserted mid-character SHALL discard the partial character with no rx_valid.
REQ-035 After reset deasserts, the block SHALL require a fresh NULL before link_up rises.

Configuration
REQ-036 With macro IEEE1355_RX_NULL_PASS_EN defined, a complete NULL in ALIGNED SHALL be presented on rx_data with rx_valid=1 and rx_is_null=1.
REQ-037 With IEEE1355_RX_NULL_PASS_EN defined, rx_is_null SHALL be 0 for non-NULL characters.
REQ-038 With IEEE1355_RX_NULL_PASS_EN undefined, rx_is_null SHALL be tied 0 and NULLs SHALL never raise rx_valid.

Verification
REQ-039 Reset, then DS stream of 3 NULLs at clk/8 bit rate -> link_up=1 after the first NULL, no rx_valid (macro off).
REQ-040 NULL, then character 10'h2A5, then NULL -> exactly one rx_valid with rx_data=10'h2A5, 1 cycle after its 10th bit shift.
REQ-041 After alignment, stop toggling D/S for 64 cycles -> link_up=0 and one rx_err pulse; resume NULLs -> link_up=1 again.
REQ-042 Force D_in and S_in to toggle in the same cycle mid-character -> rx_err pulse, FSM returns to HUNT, no rx_valid for that character.
REQ-043 Assert rst for 1 cycle during bit 5 of 10'h155 -> all outputs 0, no rx_valid, and realignment only after the next NULL.
REQ-044 With IEEE1355_RX_NULL_PASS_EN defined, send 2 NULLs after alignment -> 2 rx_valid pulses with rx_data=10'b1111000110 and rx_is_null=1.

Source files
------------

// File: rtl/ieee1355_rx.sv
// ieee1355_rx: DS-link character receiver with NULL alignment, timeout and DS-violation detection.
// Optional build macro IEEE1355_RX_NULL_PASS_EN forwards received NULLs with rx_is_null set.
module ieee1355_rx #(
    parameter int G_TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       D_in,
    input  logic       S_in,
    output logic [9:0] rx_data,
    output logic       rx_valid,
    output logic       rx_is_null,
    output logic       link_up,
    output logic       rx_err
);
    localparam logic [9:0] NULL_CHAR = 10'b1111000110;
    localparam logic [9:0] TO_MAX = 10'(G_TIMEOUT_CYCLES);
    localparam logic [9:0] TO_LAST = 10'(G_TIMEOUT_CYCLES - 1);

    typedef enum logic {HUNT, ALIGNED} state_t;

    state_t     state;
    logic       d_s1, d_s2, s_s1, s_s2, d_q, s_q;
    logic [9:0] sr, sr_next, to_cnt;
    logic [3:0] bit_cnt;
    logic       done, bit_ev, ds_viol, to_hit;

    // Event decode: parity change is a bit, both lines toggling together is illegal
    always_comb begin
        bit_ev  = (d_s2 ^ s_s2) != (d_q ^ s_q);
        ds_viol = (d_s2 != d_q) && (s_s2 != s_q);
        sr_next = {d_s2, sr[9:1]};
        to_hit  = !bit_ev && to_cnt == TO_LAST;
    end

    // Two-flop synchronisers plus one-cycle history for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            {d_s1, d_s2, s_s1, s_s2, d_q, s_q} <= '0;
        end else begin
            d_s1 <= D_in;
            d_s2 <= d_s1;
            s_s1 <= S_in;
            s_s2 <= s_s1;
            d_q  <= d_s2;
            s_q  <= s_s2;
        end
    end

    // Alignment FSM, character assembly, timeout and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            sr         <= '0;
            bit_cnt    <= '0;
            to_cnt     <= '0;
            done       <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_is_null <= 1'b0;
            link_up    <= 1'b0;
            rx_err     <= 1'b0;
        end else begin
            rx_valid   <= 1'b0;
            rx_is_null <= 1'b0;
            rx_err     <= 1'b0;
            done       <= 1'b0;
            to_cnt     <= bit_ev ? '0 : (to_cnt == TO_MAX ? to_cnt : to_cnt + 10'd1);
            if (done) begin
`ifdef IEEE1355_RX_NULL_PASS_EN
                rx_data    <= sr;
                rx_valid   <= 1'b1;
                rx_is_null <= sr == NULL_CHAR;
`else
                if (sr != NULL_CHAR) begin
                    rx_data  <= sr;
                    rx_valid <= 1'b1;
                end
`endif
            end
            if (ds_viol) begin
                state   <= HUNT;
                link_up <= 1'b0;
                rx_err  <= 1'b1;
            end else if (bit_ev) begin
                sr <= sr_next;
                if (state == HUNT) begin
                    if (sr_next == NULL_CHAR) begin
                        state   <= ALIGNED;
                        link_up <= 1'b1;
                        bit_cnt <= '0;
                    end
                end else if (bit_cnt == 4'd9) begin
                    bit_cnt <= '0;
                    done    <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (to_hit && state == ALIGNED) begin
                state   <= HUNT;
                link_up <= 1'b0;
                rx_err  <= 1'b1;
            end
        end
    end
endmodule
